// File: rtl/vga_scanout.sv
// vga_scanout: frame-buffer read controller producing 640x480@60 VGA timing.
// Counters drive a registered read address, the returned palette index is
// converted to 12-bit RGB through a registered ROM, and sync/active flags are
// delayed so that sync and colour for one pixel reach the pins together.
// Build option: define VGA_SCALE2X_EN to show the buffer pixel-doubled (2x2).
module vga_scanout #(
   parameter int RD_LATENCY = 1,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] vga_row,
   output logic [9:0] vga_col,
   input  logic [7:0] vga_data,
   output logic       hsync,
   output logic       vsync,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       vblank,
   output logic       frame_start
);

   // address register + read latency + palette register
   localparam int PIPE_DEPTH = RD_LATENCY + 2;

   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] ADDR_BLANK = 10'd1023;

   // 2C02 palette, 4 bits per channel, {R,G,B}
   localparam logic [11:0] PALETTE [64] = '{
      12'h666, 12'h029, 12'h11B, 12'h40A, 12'h608, 12'h704, 12'h710, 12'h520,
      12'h330, 12'h040, 12'h040, 12'h041, 12'h034, 12'h000, 12'h000, 12'h000,
      12'hAAA, 12'h15E, 12'h43F, 12'h73F, 12'hA2C, 12'hB27, 12'hB20, 12'h940,
      12'h660, 12'h270, 12'h080, 12'h074, 12'h068, 12'h000, 12'h000, 12'h000,
      12'hFFF, 12'h6AF, 12'h98F, 12'hC7F, 12'hF6F, 12'hF6B, 12'hF85, 12'hE90,
      12'hBB0, 12'h7D0, 12'h4E2, 12'h3D8, 12'h4CD, 12'h444, 12'h000, 12'h000,
      12'hFFF, 12'hBDF, 12'hCCF, 12'hEBF, 12'hFBF, 12'hFBD, 12'hFCB, 12'hFDA,
      12'hEE9, 12'hCF9, 12'hAFA, 12'hAFD, 12'hAEF, 12'hBBB, 12'h000, 12'h000
   };

   logic [9:0]            h_cnt_reg, h_cnt_next;
   logic [9:0]            v_cnt_reg, v_cnt_next;
   logic [9:0]            row_next, col_next;
   logic                  active_now, hsync_now, vsync_now;
   logic [PIPE_DEPTH-1:0] act_pipe_reg, hs_pipe_reg, vs_pipe_reg;
   logic [11:0]           pal_reg;
   logic                  data_unused;

   // the upper two index bits carry no colour information
   assign data_unused = ^vga_data[7:6];

   // next counter values: h wraps every line, v advances on the h wrap
   always_comb begin
      h_cnt_next = h_cnt_reg + 10'd1;
      v_cnt_next = v_cnt_reg;
      if (h_cnt_reg == H_LAST) begin
         h_cnt_next = '0;
         v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
      end
   end

   assign active_now = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
   assign hsync_now  = !((h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END));
   assign vsync_now  = !((v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END));

   // read address: the counter position in the active area, an off-buffer address otherwise
   always_comb begin
      row_next = ADDR_BLANK;
      col_next = ADDR_BLANK;
      if (active_now) begin
`ifdef VGA_SCALE2X_EN
         row_next = {1'b0, v_cnt_reg[9:1]};
         col_next = {1'b0, h_cnt_reg[9:1]};
`else
         row_next = v_cnt_reg;
         col_next = h_cnt_reg;
`endif
      end
   end

   // counters and registered read address
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
         vga_row   <= '0;
         vga_col   <= '0;
      end else begin
         h_cnt_reg <= h_cnt_next;
         v_cnt_reg <= v_cnt_next;
         vga_row   <= row_next;
         vga_col   <= col_next;
      end
   end

   // flag delay line matching the address/read/palette path
   always_ff @(posedge clk) begin
      if (rst) begin
         act_pipe_reg <= '0;
         hs_pipe_reg  <= '1;
         vs_pipe_reg  <= '1;
      end else begin
         act_pipe_reg <= {act_pipe_reg[PIPE_DEPTH-2:0], active_now};
         hs_pipe_reg  <= {hs_pipe_reg[PIPE_DEPTH-2:0], hsync_now};
         vs_pipe_reg  <= {vs_pipe_reg[PIPE_DEPTH-2:0], vsync_now};
      end
   end

   // palette ROM with registered read
   always_ff @(posedge clk) begin
      if (rst) begin
         pal_reg <= '0;
      end else begin
         pal_reg <= PALETTE[vga_data[5:0]];
      end
   end

   assign hsync              = hs_pipe_reg[PIPE_DEPTH-1];
   assign vsync              = vs_pipe_reg[PIPE_DEPTH-1];
   assign {red, green, blue} = act_pipe_reg[PIPE_DEPTH-1] ? pal_reg : 12'h000;

   // frame markers follow the counters directly; frame_start is held off during reset
   assign vblank      = (v_cnt_reg >= V_ACT);
   assign frame_start = !rst && (h_cnt_reg == '0) && (v_cnt_reg == '0);

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: self-checking bench for vga_scanout (horizontal timing at
// full size, vertical timing shortened so a whole frame is 23200 cycles).
// Pixel outputs are checked every cycle against a queue of expected values;
// address/marker behaviour is checked from a vector table and short sequences.
`timescale 1ns/1ps
module tb_vga_scanout;

   localparam int VA    = 12;
   localparam int VF    = 10;
   localparam int VS    = 2;
   localparam int VB    = 5;
   localparam int VT    = VA + VF + VS + VB;
   localparam int HT    = 800;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] vga_row, vga_col;
   logic [7:0] vga_data = 8'h00;
   logic       hsync, vsync, vblank, frame_start;
   logic [3:0] red, green, blue;

   always #5 clk = ~clk;

   vga_scanout #(
      .RD_LATENCY(1),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .rst(rst),
      .vga_row(vga_row), .vga_col(vga_col), .vga_data(vga_data),
      .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue),
      .vblank(vblank), .frame_start(frame_start)
   );

   // frame buffer model: row 0, columns 0..15 hold a set of indices, 0x30 elsewhere
   logic [7:0] pix_idx [16] = '{8'h16, 8'h30, 8'h20, 8'h12, 8'h0D, 8'h0E, 8'h0F, 8'h1D,
                                8'h1E, 8'h1F, 8'h2E, 8'h2F, 8'h3E, 8'h3F, 8'hD6, 8'h70};

   always @(posedge clk)
      vga_data <= (vga_row == 10'd0 && vga_col < 10'd16) ? pix_idx[vga_col[3:0]] : 8'h30;

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } pix_t;

   typedef struct {
      int h;
      int v;
      int row;
      int col;
      int vb;
      int fs;
   } vec_t;

   pix_t sb_q [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   m_h   = 0;
   int   m_v   = 0;
   bit   sb_on = 0;
   bit   mon_on = 0;
   int   fs_n, fs_t0, fs_t1, hf_n, hf_t0, hf_t1, hr_t0, vf_t0, vr_t0, vb_t0;
   logic hs_prev, vs_prev, vb_prev;

   function automatic logic [11:0] pal_ref(logic [5:0] i);
      case (i)
         6'h16:                        return 12'hB20;
         6'h12:                        return 12'h43F;
         6'h20, 6'h30:                 return 12'hFFF;
         6'h0D, 6'h0E, 6'h0F, 6'h1D,
         6'h1E, 6'h1F, 6'h2E, 6'h2F,
         6'h3E, 6'h3F:                 return 12'h000;
         default:                      return 12'hEEE;
      endcase
   endfunction

   function automatic pix_t exp_pix(int h, int v);
      pix_t       p;
      int         r;
      int         c;
      logic [7:0] d;
      p.hs  = !(h >= 656 && h < 752);
      p.vs  = !(v >= VA + VF && v < VA + VF + VS);
      p.rgb = 12'h000;
      if (h < 640 && v < VA) begin
`ifdef VGA_SCALE2X_EN
         r = v / 2;
         c = h / 2;
`else
         r = v;
         c = h;
`endif
         d = (r == 0 && c < 16) ? pix_idx[c[3:0]] : 8'h30;
         p.rgb = pal_ref(d[5:0]);
      end
      return p;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // one clock: advance the counter model, score the pins, watch sync edges
   task automatic step();
      logic r;
      pix_t e;
      pix_t rst_pix;
      r = rst;
      rst_pix.rgb = 12'h000;
      rst_pix.hs  = 1'b1;
      rst_pix.vs  = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         m_h = 0;
         m_v = 0;
         sb_q.delete();
         repeat (3) sb_q.push_back(rst_pix);
         sb_on = 1;
      end else if (m_h == HT - 1) begin
         m_h = 0;
         m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
         m_h++;
      end
      if (sb_on) begin
         sb_q.push_back(exp_pix(m_h, m_v));
         e = sb_q.pop_front();
         total++;
         if ({red, green, blue} !== e.rgb || hsync !== e.hs || vsync !== e.vs) begin
            bad++;
            if (bad <= 20)
               $display("FAIL pixel cycle=%0d: got rgb=%h hs=%b vs=%b required rgb=%h hs=%b vs=%b",
                        cyc, {red, green, blue}, hsync, vsync, e.rgb, e.hs, e.vs);
         end
      end
      if (mon_on) begin
         if (frame_start === 1'b1) begin
            fs_n++;
            if (fs_n == 2) fs_t1 = cyc;
         end
         if (hs_prev === 1'b1 && hsync === 1'b0) begin
            hf_n++;
            if (hf_n == 1) hf_t0 = cyc;
            else if (hf_n == 2) hf_t1 = cyc;
         end
         if (hs_prev === 1'b0 && hsync === 1'b1 && hr_t0 < 0) hr_t0 = cyc;
         if (vs_prev === 1'b1 && vsync === 1'b0 && vf_t0 < 0) vf_t0 = cyc;
         if (vs_prev === 1'b0 && vsync === 1'b1 && vr_t0 < 0) vr_t0 = cyc;
         if (vb_prev === 1'b0 && vblank === 1'b1 && vb_t0 < 0) vb_t0 = cyc;
      end
      hs_prev = hsync;
      vs_prev = vsync;
      vb_prev = vblank;
   endtask

   task automatic run_to(int h, int v);
      int n;
      n = 0;
      while (!(m_h == h && m_v == v) && n < FRAME + 10) begin
         step();
         n++;
      end
      if (!(m_h == h && m_v == v)) begin
         total++;
         bad++;
         $display("FAIL run_to: position (%0d,%0d) not reached, stopped at (%0d,%0d)", h, v, m_h, m_v);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t vecs [10];
      int   p1_rgb;

      vecs[0] = '{h: 0,   v: 0,  row: 0,    col: 0,    vb: 0, fs: 1};
`ifdef VGA_SCALE2X_EN
      vecs[1] = '{h: 15,  v: 0,  row: 0,    col: 7,    vb: 0, fs: 0};
      vecs[2] = '{h: 3,   v: 5,  row: 2,    col: 1,    vb: 0, fs: 0};
      vecs[3] = '{h: 639, v: 5,  row: 2,    col: 319,  vb: 0, fs: 0};
      vecs[6] = '{h: 0,   v: 11, row: 5,    col: 0,    vb: 0, fs: 0};
      p1_rgb  = 32'hB20;
`else
      vecs[1] = '{h: 15,  v: 0,  row: 0,    col: 15,   vb: 0, fs: 0};
      vecs[2] = '{h: 3,   v: 5,  row: 5,    col: 3,    vb: 0, fs: 0};
      vecs[3] = '{h: 639, v: 5,  row: 5,    col: 639,  vb: 0, fs: 0};
      vecs[6] = '{h: 0,   v: 11, row: 11,   col: 0,    vb: 0, fs: 0};
      p1_rgb  = 32'hFFF;
`endif
      vecs[4] = '{h: 640, v: 5,  row: 1023, col: 1023, vb: 0, fs: 0};
      vecs[5] = '{h: 700, v: 5,  row: 1023, col: 1023, vb: 0, fs: 0};
      vecs[7] = '{h: 799, v: 11, row: 1023, col: 1023, vb: 0, fs: 0};
      vecs[8] = '{h: 0,   v: 12, row: 1023, col: 1023, vb: 1, fs: 0};
      vecs[9] = '{h: 100, v: 28, row: 1023, col: 1023, vb: 1, fs: 0};

      // reset held for five cycles
      rst = 1'b1;
      repeat (5) step();
      check("reset_hsync", 32'(hsync), 1);
      check("reset_vsync", 32'(vsync), 1);
      check("reset_rgb", 32'({red, green, blue}), 0);
      check("reset_row", 32'(vga_row), 0);
      check("reset_col", 32'(vga_col), 0);
      check("reset_vblank", 32'(vblank), 0);
      check("reset_frame_start", 32'(frame_start), 0);
      $display("seq reset: hsync=%b vsync=%b rgb=%h row=%0d col=%0d", hsync, vsync, {red, green, blue}, vga_row, vga_col);

      // release: frame_start on the first cycle with rst low
      rst = 1'b0;
      #1;
      check("release_frame_start", 32'(frame_start), 1);
      $display("seq release: frame_start=%b", frame_start);
      fs_n = 1; fs_t0 = cyc; fs_t1 = -1;
      hf_n = 0; hf_t0 = -1; hf_t1 = -1; hr_t0 = -1;
      vf_t0 = -1; vr_t0 = -1; vb_t0 = -1;
      mon_on = 1;

      // address and marker vectors through one frame
      for (int i = 0; i < 10; i++) begin
         run_to(vecs[i].h, vecs[i].v);
         check("vec_vblank", 32'(vblank), vecs[i].vb);
         check("vec_frame_start", 32'(frame_start), vecs[i].fs);
         step();
         check("vec_row", 32'(vga_row), vecs[i].row);
         check("vec_col", 32'(vga_col), vecs[i].col);
         $display("vec %0d: cnt=(%0d,%0d) row=%0d col=%0d vblank=%b", i, vecs[i].h, vecs[i].v, vga_row, vga_col, vblank);
      end

      // frame wrap (799,last) -> (0,0)
      run_to(799, VT - 1);
      check("wrap_vblank_before", 32'(vblank), 1);
      check("wrap_frame_start_before", 32'(frame_start), 0);
      step();
      check("wrap_frame_start", 32'(frame_start), 1);
      check("wrap_vblank_after", 32'(vblank), 0);
      $display("seq wrap: frame_start=%b vblank=%b", frame_start, vblank);

      // timing measured across the first frame
      check("frame_period", 32'(fs_t1 - fs_t0), FRAME);
      check("frame_start_pulses", 32'(fs_n), 2);
      check("hsync_first_fall", 32'(hf_t0 - fs_t0), 659);
      check("hsync_low_width", 32'(hr_t0 - hf_t0), 96);
      check("line_period", 32'(hf_t1 - hf_t0), 800);
      check("vblank_rise", 32'(vb_t0 - fs_t0), VA * HT);
      check("vsync_first_fall", 32'(vf_t0 - fs_t0), (VA + VF) * HT + 3);
      check("vsync_low_width", 32'(vr_t0 - vf_t0), VS * HT);
      $display("seq timing: period=%0d hfall=%0d hlow=%0d vfall=%0d vlow=%0d",
               fs_t1 - fs_t0, hf_t0 - fs_t0, hr_t0 - hf_t0, vf_t0 - fs_t0, vr_t0 - vf_t0);
      mon_on = 0;

      // one-cycle reset in the middle of an active line
      run_to(300, 10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("midrst_hsync", 32'(hsync), 1);
      check("midrst_vsync", 32'(vsync), 1);
      check("midrst_rgb", 32'({red, green, blue}), 0);
      check("midrst_row", 32'(vga_row), 0);
      check("midrst_col", 32'(vga_col), 0);
      check("midrst_vblank", 32'(vblank), 0);
      check("midrst_frame_start", 32'(frame_start), 1);
      $display("seq midrst: rgb=%h row=%0d col=%0d frame_start=%b", {red, green, blue}, vga_row, vga_col, frame_start);

      // first pixels after restart reach the pins three cycles later
      repeat (3) step();
      check("pixel0_rgb", 32'({red, green, blue}), 32'hB20);
      step();
      check("pixel1_rgb", 32'({red, green, blue}), p1_rgb);
      $display("seq pixels: pixel1 rgb=%h", {red, green, blue});
      repeat (1000) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
